m72_ioctl_upload: RTL and testbench

- Upload-direction responder for the ioctl interface: serves bytes to the HPS while `ioctl_upload` is high, covering NVRAM and high-score save.
- It is the reader counterpart of the ROM download path: it fetches 16-bit words from a core memory port through a req/ack handshake and presents the addressed byte on `ioctl_din`.
- It holds `ioctl_wait` high while a fetch is outstanding.
- Sits between the top-level ioctl pins and the core's NVRAM/SDRAM arbiter; runs on `sys_clk`.

---
 rtl/m72_ioctl_pkg.sv | 15 +
 rtl/m72_word_cache.sv | 36 +++
 rtl/m72_ioctl_upload.sv | 151 +++++++++++++++
 tb/tb_m72_ioctl_upload.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/m72_ioctl_pkg.sv
// m72_ioctl_pkg: shared FSM states, ioctl region indices and the fill byte
// for the M72 ioctl upload/download paths.
package m72_ioctl_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [7:0] ROM_INDEX   = 8'h00;
    localparam logic [7:0] NVRAM_INDEX = 8'h04;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/m72_word_cache.sv
// m72_word_cache: single-entry word cache (tag, 16-bit data, valid) with
// combinational hit compare; invalidate wins over load.
module m72_word_cache #(
    parameter int TAG_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv,
    input  logic             load,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [15:0]      load_data,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic [15:0]      data
);

    logic             valid;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag_q <= '0;
            data  <= '0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            tag_q <= load_tag;
            data  <= load_data;
        end
    end

    assign hit = valid && (tag_q == tag);

endmodule

// File: rtl/m72_ioctl_upload.sv
// m72_ioctl_upload: serves upload-direction ioctl bytes from a word-wide
// memory port through a one-word cache, stalling the HPS with ioctl_wait.
module m72_ioctl_upload
    import m72_ioctl_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter int         REGION_SIZE  = 16384,
    parameter logic [7:0] UPLOAD_INDEX = NVRAM_INDEX,
    parameter int         TIMEOUT      = 255
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic              timeout_err
);

    state_t            state, state_n;
    logic [7:0]        din_n, cnt, cnt_n, pidx, pidx_n, rd_idx;
    logic              wait_n, req_n, terr_n, lsb, lsb_n, pend, pend_n, upload_q;
    logic [ADDR_W-2:0] addr_n;
    logic [24:0]       paddr, paddr_n, rd_addr;
    logic              upload_rise, rd_any, rd_valid, hit, cache_load, cnt_done;
    logic [15:0]       cache_data;

    // A read queued during DRAIN replays with its own captured address/index.
    assign rd_addr     = pend ? paddr : ioctl_addr;
    assign rd_idx      = pend ? pidx : ioctl_index;
    assign rd_any      = ioctl_upload && (ioctl_rd || pend);
    assign rd_valid    = (rd_idx == UPLOAD_INDEX) && (rd_addr < 25'(REGION_SIZE));
    assign upload_rise = ioctl_upload && !upload_q;
    assign cnt_done    = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT);

    m72_word_cache #(.TAG_W(ADDR_W-1)) u_cache (
        .clk       (sys_clk),
        .rst       (reset),
        .inv       (upload_rise),
        .load      (cache_load),
        .load_tag  (mem_addr),
        .load_data (mem_data),
        .tag       (rd_addr[ADDR_W-1:1]),
        .hit       (hit),
        .data      (cache_data)
    );

    always_comb begin
        state_n    = state;
        din_n      = ioctl_din;
        wait_n     = ioctl_wait;
        req_n      = mem_req;
        addr_n     = mem_addr;
        terr_n     = upload_rise ? 1'b0 : timeout_err;
        cnt_n      = cnt;
        lsb_n      = lsb;
        pend_n     = pend;
        paddr_n    = paddr;
        pidx_n     = pidx;
        cache_load = 1'b0;
        case (state)
            IDLE: begin
                pend_n = 1'b0;
                wait_n = 1'b0;
                if (rd_any) begin
                    if (!rd_valid) begin
                        din_n = FILL_BYTE;
                    end else if (hit) begin
                        din_n = pick_byte(cache_data, rd_addr[0]);
                    end else begin
                        state_n = FETCH;
                        req_n   = 1'b1;
                        addr_n  = rd_addr[ADDR_W-1:1];
                        wait_n  = 1'b1;
                        cnt_n   = 8'd0;
                        lsb_n   = rd_addr[0];
                    end
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_n    = IDLE;
                    req_n      = 1'b0;
                    wait_n     = 1'b0;
                    din_n      = pick_byte(mem_data, lsb);
                    cache_load = 1'b1;
                end else if (!ioctl_upload) begin
                    state_n = DRAIN;
                    wait_n  = 1'b0;
                end else if (cnt_done) begin
                    state_n = DRAIN;
                    wait_n  = 1'b0;
                    din_n   = FILL_BYTE;
                    terr_n  = 1'b1;
                end else begin
                    cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (ioctl_upload && ioctl_rd && !pend) begin
                    pend_n  = 1'b1;
                    paddr_n = ioctl_addr;
                    pidx_n  = ioctl_index;
                    wait_n  = 1'b1;
                end
                if (mem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ioctl_din   <= FILL_BYTE;
            ioctl_wait  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            timeout_err <= 1'b0;
            cnt         <= 8'd0;
            lsb         <= 1'b0;
            pend        <= 1'b0;
            paddr       <= '0;
            pidx        <= 8'd0;
            upload_q    <= 1'b0;
        end else begin
            state       <= state_n;
            ioctl_din   <= din_n;
            ioctl_wait  <= wait_n;
            mem_req     <= req_n;
            mem_addr    <= addr_n;
            timeout_err <= terr_n;
            cnt         <= cnt_n;
            lsb         <= lsb_n;
            pend        <= pend_n;
            paddr       <= paddr_n;
            pidx        <= pidx_n;
            upload_q    <= ioctl_upload;
        end
    end

endmodule

// File: tb/tb_m72_ioctl_upload.sv
// tb_m72_ioctl_upload: directed table vectors plus hand-written sequences for
// timeout, queued read, abort, async reset and a sequential stream.
module tb_m72_ioctl_upload;

    logic        sys_clk = 1'b0;
    logic        reset, ioctl_upload, ioctl_rd, mem_ack;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_index, ioctl_din;
    logic        ioctl_wait, mem_req, timeout_err;
    logic [14:0] mem_addr;
    logic [15:0] mem_data;

    int tests = 0, fails = 0;
    int lat = -1, wait_cnt = 0, n_req = 0;
    logic req_prev = 1'b0;

    m72_ioctl_upload dut (
        .sys_clk(sys_clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  idx;
        int          lat;
        logic [7:0]  din;
        int          waitc;
        int          reqs;
    } vec_t;

    function automatic logic [15:0] model_word(input logic [14:0] w);
        return (w == 15'd8) ? 16'hBEEF : {~w[7:0], w[7:0] ^ {1'b0, w[14:8]}};
    endfunction

    function automatic logic [7:0] model_byte(input logic [24:0] a);
        logic [15:0] wd;
        wd = model_word(a[15:1]);
        return a[0] ? wd[15:8] : wd[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock; also plays the memory side with ack latency 'lat' (-1 = never).
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (mem_req && !req_prev) n_req++;
        req_prev = mem_req;
        mem_ack  = 1'b0;
        if (!mem_req) begin
            wait_cnt = 0;
        end else if (lat >= 0 && wait_cnt >= lat) begin
            mem_ack  = 1'b1;
            mem_data = model_word(mem_addr);
            wait_cnt = 0;
        end else begin
            wait_cnt++;
        end
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] idx,
                           output logic [7:0] din, output int waitc, output int reqs);
        int r0;
        r0 = n_req;
        ioctl_addr  = a;
        ioctl_index = idx;
        ioctl_rd    = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        waitc = 0;
        while (ioctl_wait && waitc < 1000) begin
            waitc++;
            tick();
        end
        if (waitc >= 1000) check("wait_bound", 32'(waitc), 32'd999);
        din  = ioctl_din;
        reqs = n_req - r0;
    endtask

    vec_t vecs[9];

    initial begin
        logic [7:0] d, prev;
        int wc, rq, r0;
        vecs[0] = '{25'h0000010, 8'h04, 5, 8'hEF, 6, 1};
        vecs[1] = '{25'h0000011, 8'h04, 5, 8'hBE, 0, 0};
        vecs[2] = '{25'h0004000, 8'h04, 0, 8'hFF, 0, 0};
        vecs[3] = '{25'h0000000, 8'h00, 0, 8'hFF, 0, 0};
        vecs[4] = '{25'h0003FFF, 8'h04, 0, 8'h00, 1, 1};
        vecs[5] = '{25'h1000010, 8'h04, 0, 8'hFF, 0, 0};
        vecs[6] = '{25'h0000010, 8'h04, 2, 8'hEF, 3, 1};
        vecs[7] = '{25'h0000004, 8'h04, 1, 8'h02, 2, 1};
        vecs[8] = '{25'h0000005, 8'h04, 1, 8'hFD, 0, 0};

        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; mem_ack = 1'b0;
        ioctl_addr = '0; ioctl_index = 8'h04; mem_data = '0;
        tick(); tick();
        check("rst_din", 32'(ioctl_din), 32'hFF);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0; ioctl_upload = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            lat = vecs[i].lat;
            do_read(vecs[i].addr, vecs[i].idx, d, wc, rq);
            check($sformatf("vec%0d_din", i), 32'(d), 32'(vecs[i].din));
            check($sformatf("vec%0d_wait", i), 32'(wc), 32'(vecs[i].waitc));
            check($sformatf("vec%0d_reqs", i), 32'(rq), 32'(vecs[i].reqs));
        end
        do_read(25'h0000004, 8'h05, d, wc, rq);
        check("wrong_idx_on_hit_din", 32'(d), 32'hFF);

        // reads while upload is low are ignored
        ioctl_upload = 1'b0; tick();
        r0 = n_req;
        ioctl_addr = 25'h20; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        check("no_upload_wait", 32'(ioctl_wait), 32'd0);
        tick();
        check("no_upload_reqs", 32'(n_req - r0), 32'd0);
        ioctl_upload = 1'b1; tick();

        // timeout, then a read queued in DRAIN that hits the cached word 8
        lat = 1; do_read(25'h10, 8'h04, d, wc, rq);
        lat = -1;
        do_read(25'h20, 8'h04, d, wc, rq);
        check("to_wait_cycles", 32'(wc), 32'd255);
        check("to_din", 32'(d), 32'hFF);
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_req_held", 32'(mem_req), 32'd1);
        r0 = n_req;
        ioctl_addr = 25'h11; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        check("queued_wait_raised", 32'(ioctl_wait), 32'd1);
        lat = 0;
        for (int k = 0; k < 20 && ioctl_wait; k++) tick();
        check("queued_wait_fell", 32'(ioctl_wait), 32'd0);
        check("queued_din", 32'(ioctl_din), 32'hBE);
        check("queued_no_fetch", 32'(n_req - r0), 32'd0);
        check("terr_sticky", 32'(timeout_err), 32'd1);
        ioctl_upload = 1'b0; tick();
        ioctl_upload = 1'b1; tick();
        check("terr_cleared", 32'(timeout_err), 32'd0);
        lat = 1; do_read(25'h10, 8'h04, d, wc, rq);
        check("reread_reqs", 32'(rq), 32'd1);
        check("reread_din", 32'(d), 32'hEF);

        // upload abort mid-FETCH
        lat = -1;
        ioctl_addr = 25'h30; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        check("abort_wait_pre", 32'(ioctl_wait), 32'd1);
        prev = ioctl_din;
        ioctl_upload = 1'b0; tick();
        check("abort_wait", 32'(ioctl_wait), 32'd0);
        check("abort_req_held", 32'(mem_req), 32'd1);
        lat = 0; tick(); tick();
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_din_kept", 32'(ioctl_din), 32'(prev));
        ioctl_upload = 1'b1; tick();

        // async reset between edges while fetching
        lat = -1;
        ioctl_addr = 25'h10; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        check("ar_req_pre", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_req", 32'(mem_req), 32'd0);
        check("ar_wait", 32'(ioctl_wait), 32'd0);
        check("ar_din", 32'(ioctl_din), 32'hFF);
        #1 reset = 1'b0;
        tick();
        lat = 1; do_read(25'h10, 8'h04, d, wc, rq);
        check("ar_reread_reqs", 32'(rq), 32'd1);
        check("ar_reread_din", 32'(d), 32'hEF);

        // sequential stream over a freshly invalidated cache
        ioctl_upload = 1'b0; tick();
        ioctl_upload = 1'b1; tick();
        lat = 2; r0 = n_req;
        for (int a = 0; a < 256; a++) begin
            do_read(25'(a), 8'h04, d, wc, rq);
            check($sformatf("stream_%0h", a), 32'(d), 32'(model_byte(25'(a))));
        end
        check("stream_reqs", 32'(n_req - r0), 32'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
